core_boot_sequencer: RTL and testbench
======================================

CORE_BOOT_SEQUENCER -- requirements
Module: core_boot_sequencer

Interface
REQ-001 Parameter DATA_WORDS_P, default 1024, number of data-memory words loaded.
REQ-002 Parameter INSTR_WORDS_P, default 1024, number of instruction packets sent.
REQ-003 Parameter REG_WORDS_P, default 64, number of register packets sent.
REQ-004 Parameter PC_INIT_P, default 32'h0, net_data of the PC packet.
REQ-005 Parameter BAR_MASK_P, default 32'h2, net_data of the BAR packet.
REQ-006 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1, synchronous, active-high.
REQ-008 Port start_i, input, 1, begins a boot sequence.
REQ-009 Port rom_sel_o, output, 2: 0 = data image, 1 = instruction image, 2 = register image.
REQ-010 Port rom_addr_o, output, 10, word index into the selected image.
REQ-011 Port rom_data_i, input, 40, image word; valid exactly one cycle after rom_addr_o/rom_sel_o.
REQ-012 Port mem_valid_o, output, 1, loader write request to data memory.
REQ-013 Port mem_addr_o, output, 32, byte address of the loader write.
REQ-014 Port mem_wdata_o, output, 32, loader write data; word writes only (wen=1, byte_not_word=0).
REQ-015 Port mem_yumi_i, input, 1, memory accepted the current loader write.
REQ-016 Port mem_select_o, output, 1: 0 = loader owns data memory, 1 = core owns it.
REQ-017 Port pkt_valid_o, output, 1, net packet present this cycle (the core accepts one per cycle; there is no backpressure).
REQ-018 Port pkt_op_o, output, net_op width, uses the codebase encodings NULL, INSTR, REG, PC, BAR.
REQ-019 Port pkt_data_o, output, 32, net_data.
REQ-020 Port pkt_add_o, output, 10, net_add; the packet ID is the constant 10'b0000000001.
REQ-021 Port core_addr_i, input, 32, core data-memory address.
REQ-022 Port core_wdata_i, input, 32, core write data.
REQ-023 Port mem_out_valid_i, input, 1, memory response valid.
REQ-024 Port busy_o, output, 1, FSM not in IDLE or DONE.
REQ-025 Port pass_o, output, 1, the run ended at 32'h600DBEEF.
REQ-026 Port fail_o, output, 1, the run ended at 32'hDEADDEAD.
REQ-027 Port fail_code_o, output, 32, core_wdata_i captured on failure.

Function
REQ-028 FSM states SHALL be IDLE, LD_DATA, DRAIN, LD_INSTR, LD_REG, SEND_PC, SEND_BAR, SEND_NULL, RUN, DONE.
REQ-029 IDLE->LD_DATA on start_i=1; start_i SHALL be ignored in every state except IDLE and DONE.
REQ-030 LD_DATA, word i: rom_sel_o=0 and rom_addr_o=i; next cycle mem_valid_o=1, mem_addr_o=i*4, mem_wdata_o=rom_data_i[31:0].
REQ-031 mem_valid_o, mem_addr_o and mem_wdata_o SHALL hold stable until the cycle mem_yumi_i=1; the counter advances only on acceptance.
REQ-032 After word DATA_WORDS_P-1 is accepted -> DRAIN: one cycle, mem_valid_o=0, mem_select_o still 0.
REQ-033 DRAIN->LD_INSTR; mem_select_o SHALL be 1 from the first LD_INSTR cycle until reset or a return to LD_DATA.
REQ-034 LD_INSTR SHALL stream one packet per cycle, pipelined against the 1-cycle ROM latency.
REQ-035 LD_INSTR packet i: op=INSTR, data={16'b0, rom_data_i[15:0]}, add=i; exactly INSTR_WORDS_P packets with no gaps.
REQ-036 LD_REG packet j: op=REG, data=rom_data_i[31:0], add={4'b0, rom_data_i[37:32]}; exactly REG_WORDS_P packets.
REQ-037 LD_REG -> SEND_PC (op=PC, data=PC_INIT_P, add=0) -> SEND_BAR (op=BAR, data=BAR_MASK_P, add=24) -> SEND_NULL (op=NULL, data=32'hFFFFFFFE, add=24), one cycle each.
REQ-038 SEND_NULL->RUN; pkt_valid_o SHALL be 1 only in LD_INSTR/LD_REG packet cycles and in SEND_PC, SEND_BAR and SEND_NULL.
REQ-039 In RUN, core_addr_i=32'h600DBEEF with mem_out_valid_i=1 -> DONE, pass_o=1.
REQ-040 In RUN, core_addr_i=32'hDEADDEAD with mem_out_valid_i=1 -> DONE, fail_o=1, fail_code_o=core_wdata_i.
REQ-041 Both magic addresses can never coincide; other addresses SHALL be ignored.
REQ-042 pass_o, fail_o and fail_code_o SHALL hold in DONE; DONE+start_i clears them and enters LD_DATA with mem_select_o=0.
REQ-043 Counters SHALL be sized so count==N-1 terminates each phase; no wrap-around into the next image.

Reset
REQ-044 While reset=1 at a rising edge, next state SHALL be IDLE and all counters 0.
REQ-045 Reset values: every output 0, including mem_select_o (loader owns memory), pkt_op_o=NULL and fail_code_o=0.
REQ-046 Reset mid-sequence SHALL abort at once with no further mem_valid_o or pkt_valid_o; reset outranks start_i.

Verification
REQ-047 Params 4/4/2, ROM data word i=0x100+i, yumi always 1 -> writes addr 0,4,8,12 data 0x100..0x103, one DRAIN cycle, then 4 INSTR + 2 REG + PC + BAR + NULL packets on consecutive cycles.
REQ-048 mem_yumi_i held low 3 cycles on word 1 -> addr 4/data 0x101 stable for 4 cycles; word 2 follows the cycle after acceptance.
REQ-049 Reg image word 40'h05_DEADBEEF -> REG packet data 0xDEADBEEF, add 5.
REQ-050 In RUN, core_addr_i=DEADDEAD, wdata=7, mem_out_valid_i=1 -> fail_o=1, fail_code_o=7, DONE; the same address with valid=0 -> stays in RUN.
REQ-051 Reset asserted mid-LD_INSTR -> next cycle all outputs 0; start_i then reloads from data word 0.
REQ-052 start_i pulsed during LD_REG -> ignored, packet count unchanged; start_i in DONE -> pass_o cleared, LD_DATA entered.

Source files
------------

// File: rtl/core_boot_sequencer.sv
// rtl/core_boot_sequencer.sv - loads data memory, streams boot packets to a core, then watches for pass/fail
//
// Purpose: on start_i, copies the data image from ROM into data memory (one
// word write per acceptance), hands memory to the core, streams the
// instruction and register images as net packets, sends PC/BAR/NULL control
// packets and finally watches the core's memory traffic for the pass or
// fail magic address.
//
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   start_i              - begin a boot sequence (honoured in IDLE and DONE only)
//   rom_sel_o/rom_addr_o - image select (0 data, 1 instr, 2 reg) and word index
//   rom_data_i           - image word, one cycle after the address
//   mem_*                - loader word-write port to data memory, mem_select_o = core owns memory
//   pkt_*                - net packet stream to the core, no backpressure
//   core_addr_i, core_wdata_i, mem_out_valid_i - core memory traffic observed in RUN
//   busy_o, pass_o, fail_o, fail_code_o        - status
module core_boot_sequencer #(
   parameter int          DATA_WORDS_P  = 1024,
   parameter int          INSTR_WORDS_P = 1024,
   parameter int          REG_WORDS_P   = 64,
   parameter logic [31:0] PC_INIT_P     = 32'h0,
   parameter logic [31:0] BAR_MASK_P    = 32'h2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   output logic [1:0]  rom_sel_o,
   output logic [9:0]  rom_addr_o,
   input  logic [39:0] rom_data_i,
   output logic        mem_valid_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_yumi_i,
   output logic        mem_select_o,
   output logic        pkt_valid_o,
   output logic [2:0]  pkt_op_o,
   output logic [31:0] pkt_data_o,
   output logic [9:0]  pkt_add_o,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wdata_i,
   input  logic        mem_out_valid_i,
   output logic        busy_o,
   output logic        pass_o,
   output logic        fail_o,
   output logic [31:0] fail_code_o
);

   localparam logic [2:0] OP_NULL  = 3'd0;
   localparam logic [2:0] OP_INSTR = 3'd1;
   localparam logic [2:0] OP_REG   = 3'd2;
   localparam logic [2:0] OP_PC    = 3'd3;
   localparam logic [2:0] OP_BAR   = 3'd4;

   localparam logic [1:0] SEL_DATA  = 2'd0;
   localparam logic [1:0] SEL_INSTR = 2'd1;
   localparam logic [1:0] SEL_REG   = 2'd2;

   localparam logic [9:0] DATA_LAST  = 10'(DATA_WORDS_P - 1);
   localparam logic [9:0] INSTR_LAST = 10'(INSTR_WORDS_P - 1);
   localparam logic [9:0] REG_LAST   = 10'(REG_WORDS_P - 1);

   localparam logic [31:0] PASS_ADDR = 32'h600DBEEF;
   localparam logic [31:0] FAIL_ADDR = 32'hDEADDEAD;

   typedef enum logic [3:0] {
      IDLE, LD_DATA, DRAIN, LD_INSTR, LD_REG, SEND_PC, SEND_BAR, SEND_NULL, RUN, DONE
   } state_t;

   state_t      state;
   logic [9:0]  wr_cnt;      // data word currently offered to memory
   logic [9:0]  pkt_cnt;     // packet index within the INSTR or REG phase
   logic        fresh_q;     // first cycle of a write: ROM output still belongs to this word
   logic [31:0] hold_q;      // write data captured for the stall cycles
   logic [1:0]  stream_sel;
   logic [9:0]  stream_addr;
   logic [1:0]  unused_rom_bits;

   assign unused_rom_bits = rom_data_i[39:38];

   // The ROM address runs one word ahead of the write, so after the first
   // cycle of a write the ROM output already shows the next word; the
   // captured copy keeps the write data stable while memory stalls.
   assign mem_addr_o  = mem_valid_o ? {20'b0, wr_cnt, 2'b00} : 32'b0;
   assign mem_wdata_o = !mem_valid_o ? 32'b0 : (fresh_q ? rom_data_i[31:0] : hold_q);

   assign busy_o = (state != IDLE) && (state != DONE);

   // Next ROM position while streaming packets: instruction image runs
   // straight into the register image, and the last register word is held.
   always_comb begin
      stream_sel  = rom_sel_o;
      stream_addr = rom_addr_o + 10'd1;
      if (rom_sel_o == SEL_INSTR && rom_addr_o == INSTR_LAST) begin
         stream_sel  = SEL_REG;
         stream_addr = '0;
      end else if (rom_sel_o == SEL_REG && rom_addr_o == REG_LAST) begin
         stream_addr = rom_addr_o;
      end
   end

   // Packet payload comes straight from the ROM word of this cycle.
   always_comb begin
      pkt_data_o = '0;
      pkt_add_o  = '0;
      if (pkt_valid_o) begin
         case (pkt_op_o)
            OP_INSTR: begin
               pkt_data_o = {16'b0, rom_data_i[15:0]};
               pkt_add_o  = pkt_cnt;
            end
            OP_REG: begin
               pkt_data_o = rom_data_i[31:0];
               pkt_add_o  = {4'b0, rom_data_i[37:32]};
            end
            OP_PC: pkt_data_o = PC_INIT_P;
            OP_BAR: begin
               pkt_data_o = BAR_MASK_P;
               pkt_add_o  = 10'd24;
            end
            OP_NULL: begin
               pkt_data_o = 32'hFFFFFFFE;
               pkt_add_o  = 10'd24;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         rom_sel_o    <= SEL_DATA;
         rom_addr_o   <= '0;
         wr_cnt       <= '0;
         pkt_cnt      <= '0;
         fresh_q      <= 1'b0;
         hold_q       <= '0;
         mem_valid_o  <= 1'b0;
         mem_select_o <= 1'b0;
         pkt_valid_o  <= 1'b0;
         pkt_op_o     <= OP_NULL;
         pass_o       <= 1'b0;
         fail_o       <= 1'b0;
         fail_code_o  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  state        <= LD_DATA;
                  rom_sel_o    <= SEL_DATA;
                  rom_addr_o   <= '0;
                  wr_cnt       <= '0;
                  fresh_q      <= 1'b0;
                  mem_valid_o  <= 1'b0;
                  mem_select_o <= 1'b0;
                  pass_o       <= 1'b0;
                  fail_o       <= 1'b0;
                  fail_code_o  <= '0;
               end
            end
            LD_DATA: begin
               if (!mem_valid_o) begin
                  // address cycle for word 0 has been presented; offer it next
                  mem_valid_o <= 1'b1;
                  fresh_q     <= 1'b1;
                  if (rom_addr_o != DATA_LAST) rom_addr_o <= rom_addr_o + 10'd1;
               end else begin
                  if (fresh_q) hold_q <= rom_data_i[31:0];
                  fresh_q <= 1'b0;
                  if (mem_yumi_i) begin
                     if (wr_cnt == DATA_LAST) begin
                        state       <= DRAIN;
                        mem_valid_o <= 1'b0;
                        rom_sel_o   <= SEL_INSTR;
                        rom_addr_o  <= '0;
                     end else begin
                        wr_cnt  <= wr_cnt + 10'd1;
                        fresh_q <= 1'b1;
                        if (rom_addr_o != DATA_LAST) rom_addr_o <= rom_addr_o + 10'd1;
                     end
                  end
               end
            end
            DRAIN: begin
               state        <= LD_INSTR;
               mem_select_o <= 1'b1;
               pkt_valid_o  <= 1'b1;
               pkt_op_o     <= OP_INSTR;
               pkt_cnt      <= '0;
               rom_sel_o    <= stream_sel;
               rom_addr_o   <= stream_addr;
            end
            LD_INSTR: begin
               rom_sel_o  <= stream_sel;
               rom_addr_o <= stream_addr;
               if (pkt_cnt == INSTR_LAST) begin
                  state    <= LD_REG;
                  pkt_op_o <= OP_REG;
                  pkt_cnt  <= '0;
               end else begin
                  pkt_cnt <= pkt_cnt + 10'd1;
               end
            end
            LD_REG: begin
               if (pkt_cnt == REG_LAST) begin
                  state      <= SEND_PC;
                  pkt_op_o   <= OP_PC;
                  pkt_cnt    <= '0;
                  rom_sel_o  <= SEL_DATA;
                  rom_addr_o <= '0;
               end else begin
                  pkt_cnt    <= pkt_cnt + 10'd1;
                  rom_sel_o  <= stream_sel;
                  rom_addr_o <= stream_addr;
               end
            end
            SEND_PC: begin
               state    <= SEND_BAR;
               pkt_op_o <= OP_BAR;
            end
            SEND_BAR: begin
               state    <= SEND_NULL;
               pkt_op_o <= OP_NULL;
            end
            SEND_NULL: begin
               state       <= RUN;
               pkt_valid_o <= 1'b0;
            end
            RUN: begin
               if (mem_out_valid_i) begin
                  if (core_addr_i == PASS_ADDR) begin
                     state  <= DONE;
                     pass_o <= 1'b1;
                  end else if (core_addr_i == FAIL_ADDR) begin
                     state       <= DONE;
                     fail_o      <= 1'b1;
                     fail_code_o <= core_wdata_i;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_boot_sequencer.sv
// tb/tb_core_boot_sequencer.sv - directed self-checking bench for core_boot_sequencer
module tb_core_boot_sequencer;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [1:0]  rom_sel;
   logic [9:0]  rom_addr;
   logic [39:0] rom_data;
   logic        mem_valid, mem_yumi, mem_select;
   logic [31:0] mem_addr, mem_wdata;
   logic        pkt_valid;
   logic [2:0]  pkt_op;
   logic [31:0] pkt_data;
   logic [9:0]  pkt_add;
   logic [31:0] core_addr, core_wdata;
   logic        mem_out_valid;
   logic        busy, pass, fail;
   logic [31:0] fail_code;
   logic [158:0] all_out;

   int total = 0;
   int bad   = 0;

   core_boot_sequencer #(
      .DATA_WORDS_P(4), .INSTR_WORDS_P(4), .REG_WORDS_P(2),
      .PC_INIT_P(32'h0000_1000), .BAR_MASK_P(32'h2)
   ) dut (
      .clk(clk), .reset(reset), .start_i(start),
      .rom_sel_o(rom_sel), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
      .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_yumi_i(mem_yumi), .mem_select_o(mem_select),
      .pkt_valid_o(pkt_valid), .pkt_op_o(pkt_op), .pkt_data_o(pkt_data), .pkt_add_o(pkt_add),
      .core_addr_i(core_addr), .core_wdata_i(core_wdata), .mem_out_valid_i(mem_out_valid),
      .busy_o(busy), .pass_o(pass), .fail_o(fail), .fail_code_o(fail_code)
   );

   always #5 clk = ~clk;

   // ROM images: data word i = 0x100+i, instr word i = FF_1234_0200+i, two register words
   always @(posedge clk) begin
      case (rom_sel)
         2'd0: rom_data <= 40'h100 + {30'b0, rom_addr};
         2'd1: rom_data <= 40'hFF_1234_0200 + {30'b0, rom_addr};
         2'd2: rom_data <= (rom_addr == 10'd0) ? 40'h05_DEADBEEF : 40'hC7_CAFE_F00D;
         default: rom_data <= '1;
      endcase
   end

   assign all_out = {rom_sel, rom_addr, mem_valid, mem_addr, mem_wdata, mem_select, pkt_valid,
                     pkt_op, pkt_data, pkt_add, busy, pass, fail, fail_code};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (all_out !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_not_busy: got %b want 0", busy);
      end
   endtask

   // starts from IDLE/DONE with yumi always 1; ends at the negedge showing word 3
   task automatic test_data_load;
      mem_yumi = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({mem_valid, rom_sel, rom_addr, busy} !== {1'b0, 2'd0, 10'd0, 1'b1}) begin
         bad++;
         $display("FAIL ld_data_first: got v=%b sel=%0d addr=%0d busy=%b want 0/0/0/1", mem_valid, rom_sel, rom_addr, busy);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 32'(i * 4), 32'(32'h100 + i)}) begin
            bad++;
            $display("FAIL data_write_%0d: got v=%b addr=%h data=%h want 1/%h/%h", i, mem_valid, mem_addr, mem_wdata, i * 4, 32'h100 + i);
         end
      end
   endtask

   // begins at the negedge of the last data word; ends at the first RUN negedge
   task automatic test_packets(input bit pulse_start);
      logic [2:0]  exp_op   [9] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd0};
      logic [31:0] exp_data [9] = '{32'h200, 32'h201, 32'h202, 32'h203, 32'hDEADBEEF,
                                    32'hCAFEF00D, 32'h1000, 32'h2, 32'hFFFFFFFE};
      logic [9:0]  exp_add  [9] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd5, 10'd7, 10'd0, 10'd24, 10'd24};
      @(negedge clk);
      total++;
      if ({mem_valid, mem_select, pkt_valid, busy} !== 4'b0001) begin
         bad++;
         $display("FAIL drain: got v=%b sel=%b pv=%b busy=%b want 0/0/0/1", mem_valid, mem_select, pkt_valid, busy);
      end
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         total++;
         if ({pkt_valid, pkt_op, pkt_data, pkt_add, mem_select} !== {1'b1, exp_op[k], exp_data[k], exp_add[k], 1'b1}) begin
            bad++;
            $display("FAIL packet_%0d: got v=%b op=%0d data=%h add=%0d msel=%b want 1/%0d/%h/%0d/1",
                     k, pkt_valid, pkt_op, pkt_data, pkt_add, mem_select, exp_op[k], exp_data[k], exp_add[k]);
         end
         start = (pulse_start && k == 4);
      end
      start = 1'b0;
      @(negedge clk);
      total++;
      if ({pkt_valid, mem_valid, busy, mem_select} !== 4'b0011) begin
         bad++;
         $display("FAIL run_entry: got pv=%b mv=%b busy=%b msel=%b want 0/0/1/1", pkt_valid, mem_valid, busy, mem_select);
      end
   endtask

   task automatic test_run_fail;
      core_addr = 32'h12345678; core_wdata = 32'd3; mem_out_valid = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, pass, fail} !== 3'b100) begin
         bad++;
         $display("FAIL other_addr_ignored: got busy=%b pass=%b fail=%b want 1/0/0", busy, pass, fail);
      end
      core_addr = 32'hDEADDEAD; core_wdata = 32'd7; mem_out_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, fail} !== 2'b10) begin
         bad++;
         $display("FAIL fail_needs_valid: got busy=%b fail=%b want 1/0", busy, fail);
      end
      mem_out_valid = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, pass, fail, fail_code} !== {3'b001, 32'd7}) begin
         bad++;
         $display("FAIL fail_detect: got busy=%b pass=%b fail=%b code=%h want 0/0/1/7", busy, pass, fail, fail_code);
      end
      core_addr = 32'h600DBEEF; core_wdata = 32'd9;
      @(negedge clk);
      mem_out_valid = 1'b0;
      total++;
      if ({busy, pass, fail, fail_code} !== {3'b001, 32'd7}) begin
         bad++;
         $display("FAIL done_hold: got busy=%b pass=%b fail=%b code=%h want 0/0/1/7", busy, pass, fail, fail_code);
      end
   endtask

   task automatic test_stall_restart;
      mem_yumi = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({busy, fail, fail_code, mem_select, rom_addr, mem_valid} !== {1'b1, 1'b0, 32'd0, 1'b0, 10'd0, 1'b0}) begin
         bad++;
         $display("FAIL restart_clear: got busy=%b fail=%b code=%h msel=%b addr=%0d v=%b want 1/0/0/0/0/0",
                  busy, fail, fail_code, mem_select, rom_addr, mem_valid);
      end
      @(negedge clk);
      total++;
      if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 32'd0, 32'h100}) begin
         bad++;
         $display("FAIL stall_word0: got v=%b addr=%h data=%h want 1/0/100", mem_valid, mem_addr, mem_wdata);
      end
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         total++;
         if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 32'd4, 32'h101}) begin
            bad++;
            $display("FAIL stall_hold_%0d: got v=%b addr=%h data=%h want 1/4/101", s, mem_valid, mem_addr, mem_wdata);
         end
         mem_yumi = (s == 3);
      end
      for (int i = 2; i < 4; i++) begin
         @(negedge clk);
         total++;
         if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 32'(i * 4), 32'(32'h100 + i)}) begin
            bad++;
            $display("FAIL stall_word%0d: got v=%b addr=%h data=%h want 1/%h/%h", i, mem_valid, mem_addr, mem_wdata, i * 4, 32'h100 + i);
         end
      end
   endtask

   task automatic test_run_pass;
      core_addr = 32'h600DBEEF; core_wdata = 32'd0; mem_out_valid = 1'b1;
      @(negedge clk);
      mem_out_valid = 1'b0;
      total++;
      if ({busy, pass, fail} !== 3'b010) begin
         bad++;
         $display("FAIL pass_detect: got busy=%b pass=%b fail=%b want 0/1/0", busy, pass, fail);
      end
   endtask

   task automatic test_reset_mid;
      test_data_load();
      repeat (3) @(negedge clk);
      total++;
      if ({pkt_valid, pkt_op, pkt_add} !== {1'b1, 3'd1, 10'd1}) begin
         bad++;
         $display("FAIL pre_reset_instr: got v=%b op=%0d add=%0d want 1/1/1", pkt_valid, pkt_op, pkt_add);
      end
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      total++;
      if (all_out !== '0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got %h want 0", all_out);
      end
      @(negedge clk);
      total++;
      if ({busy, mem_valid, pkt_valid} !== 3'b000) begin
         bad++;
         $display("FAIL reset_over_start: got busy=%b mv=%b pv=%b want 0/0/0", busy, mem_valid, pkt_valid);
      end
      reset = 1'b0;
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({busy, rom_sel, rom_addr, mem_valid} !== {1'b1, 2'd0, 10'd0, 1'b0}) begin
         bad++;
         $display("FAIL reload_start: got busy=%b sel=%0d addr=%0d v=%b want 1/0/0/0", busy, rom_sel, rom_addr, mem_valid);
      end
      @(negedge clk);
      total++;
      if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 32'd0, 32'h100}) begin
         bad++;
         $display("FAIL reload_word0: got v=%b addr=%h data=%h want 1/0/100", mem_valid, mem_addr, mem_wdata);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mem_yumi = 1'b1;
      core_addr = '0; core_wdata = '0; mem_out_valid = 1'b0;
      test_reset();
      test_data_load();
      test_packets(1'b0);
      test_run_fail();
      test_stall_restart();
      test_packets(1'b1);
      test_run_pass();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
